// File: rtl/spike_pkg.sv
`default_nettype none
//==============================================================================
// Module      : spike_pkg
// Description : Shared types and constants for the spike-rate decoding blocks.
//               Holds the decoder FSM state encoding, the default widths, the
//               saturation ceiling of the spike counter, and the length that a
//               window_len of zero stands for.
// Revision    : 1.0 - initial release
//==============================================================================
package spike_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int unsigned c_def_window_w = 8;
    localparam int unsigned c_def_count_w  = 8;

    // Highest representable spike count at the default width.
    localparam int unsigned c_sat_max = (1 << c_def_count_w) - 1;

    // window_len == 0 selects the longest window, 2^WINDOW_W cycles.
    localparam int unsigned c_window_zero_len = 1 << c_def_window_w;

endpackage : spike_pkg
`default_nettype wire

// File: rtl/spike_sat_counter.sv
`default_nettype none
//==============================================================================
// Module      : spike_sat_counter
// Description : COUNT_W-bit saturating event counter with synchronous clear.
//               o_count_next is the total including the current i_inc, so a
//               caller can capture the final value on the same edge that
//               clears the counter. Clear wins over increment.
// Ports       : clk          - clock, rising edge
//               rst          - synchronous reset, active low
//               i_clr        - clear the count to zero on this edge
//               i_inc        - add one on this edge (saturating)
//               o_count_next - current count plus i_inc, saturated
// Revision    : 1.0 - initial release
//==============================================================================
module spike_sat_counter
    import spike_pkg::*;
#(
    parameter int unsigned COUNT_W = c_def_count_w
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_inc,
    output logic [COUNT_W-1:0] o_count_next
);

    localparam logic [COUNT_W-1:0] c_max = '1;

    logic [COUNT_W-1:0] r_count;

    // Holding at the ceiling instead of wrapping keeps a saturated window
    // from reading back as a near-silent one.
    assign o_count_next = (i_inc && (r_count != c_max)) ? (r_count + 1'b1) : r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else begin
            r_count <= o_count_next;
        end
    end

endmodule : spike_sat_counter
`default_nettype wire

// File: rtl/spike_rate_decoder.sv
`default_nettype none
//==============================================================================
// Module      : spike_rate_decoder
// Description : Counts spikes over back-to-back windows of window_len cycles
//               and offers each saturated count on a valid/ready port.
//               A result that arrives while the port is still occupied is
//               dropped and flags the sticky overrun bit.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous reset, active low
//               en         - run enable; low aborts the current window
//               spike_in   - spike train, one spike per cycle when high
//               window_len - window length in cycles, 0 = 2^WINDOW_W
//               rate       - spike count of the last accepted window
//               rate_valid - rate holds an unconsumed result
//               rate_ready - downstream accepts rate on valid && ready
//               overrun    - sticky, a completed result was dropped
//               busy       - high while a window is being counted
// Revision    : 1.0 - initial release
//==============================================================================
module spike_rate_decoder
    import spike_pkg::*;
#(
    parameter int unsigned WINDOW_W = c_def_window_w,
    parameter int unsigned COUNT_W  = c_def_count_w
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                spike_in,
    input  logic [WINDOW_W-1:0] window_len,
    output logic [COUNT_W-1:0]  rate,
    output logic                rate_valid,
    input  logic                rate_ready,
    output logic                overrun,
    output logic                busy
);

    state_t              r_state;
    state_t              w_state_next;

    logic [WINDOW_W-1:0] r_cyc;
    logic [WINDOW_W-1:0] r_last;
    logic [COUNT_W-1:0]  r_rate;
    logic                r_rate_valid;
    logic                r_overrun;

    logic                w_start;
    logic                w_sample;
    logic                w_win_end;
    logic                w_handshake;
    logic [COUNT_W-1:0]  w_final;

    assign w_start     = (r_state == IDLE) && en;
    assign w_sample    = (r_state == COUNT) && en;
    assign w_win_end   = w_sample && (r_cyc == r_last);
    assign w_handshake = r_rate_valid && rate_ready;

    //--------------------------------------------------------------------------
    // FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (en)  w_state_next = COUNT;
            COUNT:   if (!en) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Cycle counter. The index of the last sampling edge is stored rather
    // than the length: window_len - 1 wraps 0 to all-ones, which is exactly
    // the last index of a 2^WINDOW_W window, so no extra counter bit is needed.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cyc  <= '0;
            r_last <= '0;
        end else if (w_start || w_win_end) begin
            r_cyc  <= '0;
            r_last <= window_len - 1'b1;
        end else if (w_sample) begin
            r_cyc  <= r_cyc + 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Spike counter. Cleared at the start edge and at every window end so the
    // following edge is the first sample of a fresh window.
    //--------------------------------------------------------------------------
    spike_sat_counter #(
        .COUNT_W (COUNT_W)
    ) u_spike_cnt (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_start || w_win_end),
        .i_inc        (w_sample && spike_in),
        .o_count_next (w_final)
    );

    //--------------------------------------------------------------------------
    // Output register. A new result may load when the slot is empty or is
    // being emptied on the same edge; otherwise it is lost and flagged.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rate       <= '0;
            r_rate_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_win_end && (!r_rate_valid || w_handshake)) begin
            r_rate       <= w_final;
            r_rate_valid <= 1'b1;
        end else if (w_win_end) begin
            r_overrun    <= 1'b1;
        end else if (w_handshake) begin
            r_rate_valid <= 1'b0;
        end
    end

    assign rate       = r_rate;
    assign rate_valid = r_rate_valid;
    assign overrun    = r_overrun;
    assign busy       = (r_state == COUNT);

endmodule : spike_rate_decoder
`default_nettype wire

// File: tb/tb_spike_rate_decoder.sv
`default_nettype none
//==============================================================================
// Module      : tb_spike_rate_decoder
// Description : Self-checking bench for spike_rate_decoder. Each scenario task
//               pushes the rates it expects into a queue; a monitor pops and
//               compares one entry on every output handshake.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_spike_rate_decoder;

    localparam int WW = 8;
    localparam int CW = 8;

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          en         = 1'b0;
    logic          spike_in   = 1'b0;
    logic          rate_ready = 1'b0;
    logic [WW-1:0] window_len = '0;
    logic [CW-1:0] rate;
    logic          rate_valid;
    logic          overrun;
    logic          busy;

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] mon_exp;

    always #5 clk = ~clk;

    spike_rate_decoder #(
        .WINDOW_W (WW),
        .COUNT_W  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .spike_in   (spike_in),
        .window_len (window_len),
        .rate       (rate),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .overrun    (overrun),
        .busy       (busy)
    );

    // Inputs change 1 time unit after each rising edge; outputs are read then.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a handshake takes place on the next rising edge.
    always @(negedge clk) begin
        if (rst === 1'b1 && rate_valid === 1'b1 && rate_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: rate=%0d delivered, no result expected", rate);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rate !== mon_exp) begin
                    errors++;
                    $display("FAIL scoreboard_rate: got %0d expected %0d", rate, mon_exp);
                end
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b0; en = 1'b0; spike_in = 1'b0; rate_ready = 1'b0;
        step(); step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; spike_in = 1'b1; rate_ready = 1'b0; window_len = 8'd4;
        step(); step(); step();
        checks++; if (rate !== 8'd0)      begin errors++; $display("FAIL reset_rate: got %0d expected 0", rate); end
        checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rate_valid); end
        checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        en = 1'b0; spike_in = 1'b0;
        rst = 1'b1;
        step();
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic_rate();
        apply_reset();
        window_len = 8'd10; rate_ready = 1'b1; en = 1'b1; spike_in = 1'b0;
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        for (int w = 0; w < 3; w++) begin
            exp_q.push_back(8'd5);
            for (int k = 0; k < 10; k++) begin
                spike_in = (k % 2 == 0);
                step();
                if (k == 8) begin
                    checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: window %0d got %b expected 0", w, rate_valid); end
                end
            end
            checks++; if (rate_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: window %0d got %b expected 1", w, rate_valid); end
            checks++; if (rate !== 8'd5)       begin errors++; $display("FAIL basic_rate: window %0d got %0d expected 5", w, rate); end
        end
        spike_in = 1'b0; en = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || rate_valid !== 1'b0) begin errors++; $display("FAIL basic_stop: busy=%b valid=%b expected 0 0", busy, rate_valid); end
    endtask

    task automatic test_saturation();
        apply_reset();
        window_len = 8'd0; rate_ready = 1'b1; en = 1'b1; spike_in = 1'b1;
        step();
        exp_q.push_back(8'd255);
        for (int k = 0; k < 256; k++) begin
            step();
            if (k == 254) begin
                checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL sat_early_valid: got %b expected 0", rate_valid); end
            end
        end
        checks++; if (rate_valid !== 1'b1) begin errors++; $display("FAIL sat_valid: got %b expected 1", rate_valid); end
        checks++; if (rate !== 8'd255)     begin errors++; $display("FAIL sat_rate: got %0d expected 255", rate); end
        en = 1'b0; spike_in = 1'b0;
        step();
        checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL sat_consumed: got %b expected 0", rate_valid); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        window_len = 8'd4; rate_ready = 1'b0; en = 1'b1; spike_in = 1'b0;
        step();
        exp_q.push_back(8'd4);
        // Window 1: four spikes; window 2: none (dropped); window 3: 1,0,1,1.
        for (int s = 1; s <= 10; s++) begin
            spike_in = (s <= 4) || (s == 9);
            step();
            if (s == 4) begin
                checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_overrun_early: got %b expected 0", overrun); end
            end
            if (s >= 4) begin
                checks++; if (rate_valid !== 1'b1 || rate !== 8'd4) begin errors++; $display("FAIL bp_hold: s=%0d valid=%b rate=%0d expected 1 4", s, rate_valid, rate); end
            end
            if (s == 8) begin
                checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %b expected 1", overrun); end
            end
        end
        rate_ready = 1'b1; spike_in = 1'b1;
        step();
        checks++; if (rate_valid !== 1'b0 || rate !== 8'd4) begin errors++; $display("FAIL bp_handshake: valid=%b rate=%0d expected 0 4", rate_valid, rate); end
        exp_q.push_back(8'd3);
        step();
        checks++; if (rate_valid !== 1'b1 || rate !== 8'd3) begin errors++; $display("FAIL bp_third: valid=%b rate=%0d expected 1 3", rate_valid, rate); end
        en = 1'b0; spike_in = 1'b0;
        step();
        checks++; if (rate_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b1) begin errors++; $display("FAIL bp_end: valid=%b busy=%b overrun=%b expected 0 0 1", rate_valid, busy, overrun); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        window_len = 8'd3; rate_ready = 1'b0; en = 1'b1; spike_in = 1'b0;
        step();
        exp_q.push_back(8'd3);
        exp_q.push_back(8'd1);
        for (int s = 1; s <= 6; s++) begin
            spike_in   = (s <= 4);
            rate_ready = (s == 6);
            step();
            if (s == 4 || s == 5) begin
                checks++; if (rate_valid !== 1'b1 || rate !== 8'd3) begin errors++; $display("FAIL b2b_hold: s=%0d valid=%b rate=%0d expected 1 3", s, rate_valid, rate); end
            end
        end
        checks++; if (rate_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", rate_valid); end
        checks++; if (rate !== 8'd1)       begin errors++; $display("FAIL b2b_rate: got %0d expected 1", rate); end
        checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
        rate_ready = 1'b1; en = 1'b0; spike_in = 1'b0;
        step();
        checks++; if (rate_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL b2b_end: valid=%b overrun=%b expected 0 0", rate_valid, overrun); end
    endtask

    task automatic test_abort();
        apply_reset();
        window_len = 8'd2; rate_ready = 1'b0; en = 1'b1; spike_in = 1'b1;
        step();
        exp_q.push_back(8'd2);
        step();
        window_len = 8'd20;
        step();
        checks++; if (rate_valid !== 1'b1 || rate !== 8'd2) begin errors++; $display("FAIL abort_setup: valid=%b rate=%0d expected 1 2", rate_valid, rate); end
        // Seven spikes in a 20-cycle window; a mid-window length change must be ignored.
        for (int s = 1; s <= 11; s++) begin
            spike_in = (s <= 7);
            if (s == 2) window_len = 8'd3;
            step();
        end
        checks++; if (overrun !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL abort_midwindow: overrun=%b busy=%b expected 0 1", overrun, busy); end
        en = 1'b0; spike_in = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (rate_valid !== 1'b1 || rate !== 8'd2 || overrun !== 1'b0) begin errors++; $display("FAIL abort_output: valid=%b rate=%0d overrun=%b expected 1 2 0", rate_valid, rate, overrun); end
        window_len = 8'd5; spike_in = 1'b1; en = 1'b1; rate_ready = 1'b1;
        step();
        exp_q.push_back(8'd5);
        for (int k = 0; k < 5; k++) step();
        checks++; if (rate_valid !== 1'b1 || rate !== 8'd5) begin errors++; $display("FAIL abort_restart: valid=%b rate=%0d expected 1 5", rate_valid, rate); end
        en = 1'b0; spike_in = 1'b0;
        step();
    endtask

    task automatic test_reset_midwindow();
        apply_reset();
        window_len = 8'd1; rate_ready = 1'b0; en = 1'b1; spike_in = 1'b1;
        step();
        step();
        window_len = 8'd8;
        step();
        checks++; if (overrun !== 1'b1 || rate_valid !== 1'b1 || rate !== 8'd1) begin errors++; $display("FAIL rstmid_setup: overrun=%b valid=%b rate=%0d expected 1 1 1", overrun, rate_valid, rate); end
        for (int k = 0; k < 3; k++) step();
        rst = 1'b0;
        step();
        checks++; if (rate !== 8'd0 || rate_valid !== 1'b0) begin errors++; $display("FAIL rstmid_output: rate=%0d valid=%b expected 0 0", rate, rate_valid); end
        checks++; if (overrun !== 1'b0 || busy !== 1'b0)    begin errors++; $display("FAIL rstmid_flags: overrun=%b busy=%b expected 0 0", overrun, busy); end
        rst = 1'b1; rate_ready = 1'b1; spike_in = 1'b0;
        step();
        exp_q.push_back(8'd2);
        for (int k = 0; k < 8; k++) begin
            spike_in = (k < 2);
            step();
        end
        checks++; if (rate_valid !== 1'b1 || rate !== 8'd2) begin errors++; $display("FAIL rstmid_result: valid=%b rate=%0d expected 1 2", rate_valid, rate); end
        en = 1'b0; spike_in = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic_rate();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_reset_midwindow();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d results pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_spike_rate_decoder
`default_nettype wire
